// File: rtl/sram_ctrl_if.sv
// CPU-side single-byte request/response bus into the SRAM controller.
interface sram_ctrl_if;
  logic        req;
  logic        we;
  logic [18:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, we, addr, wdata, input  busy, ack, rdata);
  modport slave  (input  req, we, addr, wdata, output busy, ack, rdata);
endinterface

// File: rtl/sram_ctrl.sv
// Strobe sequencer for the external async byte SRAM: programmable read/write
// wait states plus an idle turnaround after every access. All outputs registered.
module sram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  sram_ctrl_if.slave  bus,
  output logic [18:0] sram_addr,
  output logic        sram_cen,
  output logic        sram_wen,
  output logic        sram_oen,
  output logic        sram_oe,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din
);

  // One down-counter shared by every timed state, so it also covers TURN.
  localparam int MAXW = (RD_WAIT > WR_WAIT) ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                            : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] TN_LD = CW'((TURN > 0) ? TURN - 1 : 0);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_TURN     = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          fin;

  // Last edge of an access: ack, release strobes, then turnaround or idle.
  assign fin = ((state == S_RD) && (cnt == '0)) || (state == S_WR_HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_oen  <= 1'b1;
      sram_oe   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= 1'b0;
      case (state)
        S_IDLE: if (bus.req) begin
          sram_addr <= bus.addr;
          sram_dout <= bus.wdata;
          sram_cen  <= 1'b0;
          bus.busy  <= 1'b1;
          if (bus.we) begin
            state   <= S_WR_SETUP;
            sram_oe <= 1'b1;
          end else begin
            state    <= S_RD;
            cnt      <= RD_LD;
            sram_oen <= 1'b0;
          end
        end
        S_RD: begin
          if (cnt == '0) bus.rdata <= sram_din;
          else           cnt <= cnt - 1'b1;
        end
        S_WR_SETUP: begin
          state    <= S_WR_PULSE;
          cnt      <= WR_LD;
          sram_wen <= 1'b0;
        end
        S_WR_PULSE: begin
          if (cnt == '0) begin
            state    <= S_WR_HOLD;
            sram_wen <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WR_HOLD: ;
        S_TURN: begin
          if (cnt == '0) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          sram_cen <= 1'b1;
          sram_wen <= 1'b1;
          sram_oen <= 1'b1;
          sram_oe  <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase

      if (fin) begin
        bus.ack  <= 1'b1;
        sram_cen <= 1'b1;
        sram_wen <= 1'b1;
        sram_oen <= 1'b1;
        sram_oe  <= 1'b0;
        if (TURN == 0) begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end else begin
          state <= S_TURN;
          cnt   <= TN_LD;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: default controller plus a RD_WAIT=1/WR_WAIT=4/TURN=0 copy, each on an SRAM model.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus0();
  sram_ctrl_if bus1();

  logic [18:0] sa0, sa1;
  logic        cen0, wen0, oen0, oe0, cen1, wen1, oen1, oe1;
  logic [7:0]  do0, di0, do1, di1;

  sram_ctrl u0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .sram_addr(sa0),
    .sram_cen(cen0), .sram_wen(wen0), .sram_oen(oen0), .sram_oe(oe0),
    .sram_dout(do0), .sram_din(di0));

  sram_ctrl #(.RD_WAIT(1), .WR_WAIT(4), .TURN(0)) u1 (.clk(clk), .reset_n(reset_n),
    .bus(bus1), .sram_addr(sa1), .sram_cen(cen1), .sram_wen(wen1), .sram_oen(oen1),
    .sram_oe(oe1), .sram_dout(do1), .sram_din(di1));

  // Async SRAM models: preload table read-only, writes land at WEn rising.
  logic [7:0] mem0 [bit [18:0]];
  logic [7:0] pre0 [bit [18:0]];
  logic [7:0] mem1 [bit [18:0]];
  logic [7:0] pre1 [bit [18:0]];

  function automatic logic [7:0] rdmem(input int s, input logic [18:0] a);
    if (s == 0) return mem0.exists(a) ? mem0[a] : (pre0.exists(a) ? pre0[a] : 8'h00);
    return mem1.exists(a) ? mem1[a] : (pre1.exists(a) ? pre1[a] : 8'h00);
  endfunction

  always @(sa0 or cen0 or oen0) di0 = (!cen0 && !oen0) ? rdmem(0, sa0) : 8'h00;
  always @(sa1 or cen1 or oen1) di1 = (!cen1 && !oen1) ? rdmem(1, sa1) : 8'h00;
  always @(posedge wen0) if (!cen0) mem0[sa0] = do0;
  always @(posedge wen1) if (!cen1) mem1[sa1] = do1;

  int ct0 = 0, ct1 = 0;
  always @(negedge clk) begin
    if (oe0 && !oen0) ct0++;
    if (oe1 && !oen1) ct1++;
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0] last_rd [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // {busy, ack, cen, wen, oen, oe}
  function automatic logic [5:0] obs(input int s);
    if (s == 0) return {bus0.busy, bus0.ack, cen0, wen0, oen0, oe0};
    return {bus1.busy, bus1.ack, cen1, wen1, oen1, oe1};
  endfunction

  function automatic logic [7:0] ordata(input int s);
    return (s == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  function automatic logic [18:0] oaddr(input int s);
    return (s == 0) ? sa0 : sa1;
  endfunction

  function automatic logic [7:0] odout(input int s);
    return (s == 0) ? do0 : do1;
  endfunction

  task automatic drive(input int s, input logic r, input logic w,
                       input logic [18:0] a, input logic [7:0] d);
    if (s == 0) begin bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d; end
    else        begin bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One access, checked cycle by cycle; k indexes samples taken after edge E0+k.
  task automatic xfer(input int s, input logic w, input logic [18:0] a, input logic [7:0] d,
                      input logic ign, input logic [7:0] exp_rd);
    int rdw, wrw, trn, ka, kb;
    logic [5:0] e;
    logic [7:0] er;
    rdw = (s == 0) ? 2 : 1;
    wrw = (s == 0) ? 2 : 4;
    trn = (s == 0) ? 1 : 0;
    ka  = w ? 2 + wrw : rdw;
    kb  = ka + trn;
    drive(s, 1'b1, w, a, d);
    tick();
    drive(s, 1'b0, ~w, a ^ 19'h1, d ^ 8'hFF);
    for (int k = 0; k <= kb + 1; k++) begin
      if (ign && k == 1)  drive(s, 1'b1, 1'b0, a ^ 19'h5A5A5, 8'h00);
      if (ign && k == ka) drive(s, 1'b0, 1'b0, 19'h0, 8'h00);
      e[5] = (k < kb);
      e[4] = (k == ka);
      if (w) begin
        e[3] = !(k < 2 + wrw);
        e[2] = !(k >= 1 && k <= wrw);
        e[1] = 1'b1;
        e[0] = (k < 2 + wrw);
      end else begin
        e[3] = !(k < rdw);
        e[2] = 1'b1;
        e[1] = !(k < rdw);
        e[0] = 1'b0;
      end
      er = (!w && k >= ka) ? exp_rd : last_rd[s];
      chk($sformatf("s%0d %s %05h k%0d busy/ack/cen/wen/oen/oe", s, w ? "wr" : "rd", a, k), 32'(obs(s)), 32'(e));
      chk($sformatf("s%0d %s k%0d rdata", s, w ? "wr" : "rd", k), 32'(ordata(s)), 32'(er));
      chk($sformatf("s%0d %s k%0d sram_addr", s, w ? "wr" : "rd", k), 32'(oaddr(s)), 32'(a));
      if (w && k < 2 + wrw) chk($sformatf("s%0d wr k%0d sram_dout", s, k), 32'(odout(s)), 32'(d));
      tick();
    end
    if (w) chk($sformatf("s%0d mem[%05h]", s, a), 32'(rdmem(s, a)), 32'(d));
    else   last_rd[s] = exp_rd;
  endtask

  typedef struct {
    int          s;
    logic        w;
    logic [18:0] a;
    logic [7:0]  d;
    logic        pv;
    logic [7:0]  pd;
    logic        ign;
    logic [7:0]  er;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [10:0] ack_seen, busy_seen;
    logic [7:0]  rd_b2b;

    tbl[0] = '{0, 1'b0, 19'h12345, 8'h00, 1'b1, 8'hA5, 1'b0, 8'hA5};
    tbl[1] = '{0, 1'b1, 19'h7FFFF, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{0, 1'b0, 19'h12345, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    tbl[3] = '{0, 1'b0, 19'h7FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C};
    tbl[4] = '{1, 1'b0, 19'h00001, 8'h00, 1'b1, 8'h81, 1'b0, 8'h81};
    tbl[5] = '{1, 1'b1, 19'h40000, 8'h7E, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[6] = '{1, 1'b0, 19'h40000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h7E};
    tbl[7] = '{1, 1'b1, 19'h00001, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[8] = '{1, 1'b0, 19'h00001, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};

    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    drive(0, 1'b0, 1'b0, 19'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 19'h0, 8'h00);

    #12;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("s%0d reset strobes", s), 32'(obs(s)), 32'(6'b001110));
      chk($sformatf("s%0d reset rdata", s), 32'(ordata(s)), 32'h0);
      chk($sformatf("s%0d reset addr", s), 32'(oaddr(s)), 32'h0);
    end
    reset_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].pv) begin
        if (tbl[i].s == 0) pre0[tbl[i].a] = tbl[i].pd;
        else               pre1[tbl[i].a] = tbl[i].pd;
      end
      xfer(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ign, tbl[i].er);
    end

    // Write then read of the same byte with req held high throughout.
    ack_seen  = '0;
    busy_seen = '0;
    rd_b2b    = 8'h00;
    drive(0, 1'b1, 1'b1, 19'h00000, 8'h55);
    tick();
    drive(0, 1'b1, 1'b0, 19'h00000, 8'h00);
    for (int k = 0; k <= 10; k++) begin
      ack_seen[k]  = bus0.ack;
      busy_seen[k] = bus0.busy;
      if (k == 6) drive(0, 1'b0, 1'b0, 19'h00000, 8'h00);
      if (k == 8) rd_b2b = bus0.rdata;
      tick();
    end
    chk("b2b ack cycles", 32'(ack_seen), 32'(11'b001_0001_0000));
    chk("b2b busy cycles", 32'(busy_seen), 32'(11'b001_1101_1111));
    chk("b2b rdata", 32'(rd_b2b), 32'h55);
    last_rd[0] = 8'h55;

    // Reset asserted in the middle of the write pulse.
    drive(0, 1'b1, 1'b1, 19'h01234, 8'h99);
    tick();
    drive(0, 1'b0, 1'b0, 19'h0, 8'h00);
    tick();
    chk("midwr wen low before reset", 32'(wen0), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("midwr reset strobes", 32'(obs(0)), 32'(6'b001110));
    chk("midwr reset rdata", 32'(bus0.rdata), 32'h0);
    chk("midwr reset addr/dout", 32'({sa0, do0}), 32'h0);
    tick();
    reset_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    tick();
    tick();
    chk("post-reset idle", 32'(obs(0)), 32'(6'b001110));
    xfer(0, 1'b0, 19'h12345, 8'h00, 1'b0, 8'hA5);

    chk("s0 oe/oen overlap cycles", 32'(ct0), 32'h0);
    chk("s1 oe/oen overlap cycles", 32'(ct1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
